// File: rtl/swipt_gate_drive.sv
`timescale 1ns/1ps
// swipt_gate_drive
// Converts a requested frequency in Hz into a period in clock cycles with a
// 32-step restoring divider. Drives a complementary half-bridge gate pair as
// a 50 % square wave with dead time in front of each gate turning on.
// A new period is taken only at a period boundary, so the power stage never
// sees a shortened or stretched cycle.
module swipt_gate_drive #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int PER_W    = 24,
    parameter int DEADTIME = 50,
    parameter int FMIN     = 30000,
    parameter int FMAX     = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [19:0]      freq,
    output logic             gate_hi,
    output logic             gate_lo,
    output logic [PER_W-1:0] period_cycles,
    output logic [19:0]      freq_applied,
    output logic             period_start,
    output logic             busy
);

    localparam logic [31:0]      DIVIDEND = 32'(CLK_HZ);
    localparam logic [19:0]      FMIN_F   = 20'(FMIN);
    localparam logic [19:0]      FMAX_F   = 20'(FMAX);
    localparam logic [PER_W-1:0] DEAD     = PER_W'(DEADTIME);
    localparam logic [PER_W-1:0] ONE      = PER_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        DT_A,
        HI,
        DT_B,
        LO
    } state_t;

    // Requested frequency after clamping into the supported band.
    logic [19:0] fc;

    // Divider state.
    logic [19:0] last_req;
    logic [19:0] divisor;
    logic [19:0] rem;
    logic [31:0] quo;
    logic [4:0]  div_cnt;
    logic [20:0] rem_shift;
    logic [19:0] rem_diff;
    logic        q_bit;
    logic        div_done;

    // Result waiting for the next period boundary.
    logic             pending_valid;
    logic [PER_W-1:0] pending_period;
    logic [19:0]      pending_freq;

    // Gate sequencer.
    state_t           state;
    state_t           state_next;
    logic [PER_W-1:0] phase_cnt;
    logic [PER_W-1:0] phase_next;
    logic             load_period;
    logic [PER_W-1:0] half;
    logic [PER_W-1:0] hi_len;
    logic [PER_W-1:0] lo_len;
    logic             gate_hi_d;
    logic             gate_lo_d;
    logic             start_d;

    // Clamp the request; the lower bound also keeps the divisor non-zero.
    always_comb begin
        if (freq < FMIN_F) begin
            fc = FMIN_F;
        end else if (freq > FMAX_F) begin
            fc = FMAX_F;
        end else begin
            fc = freq;
        end
    end

    // One restoring-division step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem, quo[31]};
        q_bit     = (rem_shift >= {1'b0, divisor});
        rem_diff  = 20'(rem_shift - {1'b0, divisor});
        div_done  = busy && (div_cnt == 5'd31);
    end

    // Divider control: start on a changed request, run 32 steps, never abort except on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            div_cnt  <= '0;
            last_req <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
        end else if (busy) begin
            rem     <= q_bit ? rem_diff : rem_shift[19:0];
            quo     <= {quo[30:0], q_bit};
            div_cnt <= div_cnt + 5'd1;
            if (div_done) begin
                busy <= 1'b0;
            end
        end else if (fc != last_req) begin
            last_req <= fc;
            divisor  <= fc;
            rem      <= '0;
            quo      <= DIVIDEND;
            div_cnt  <= '0;
            busy     <= 1'b1;
        end
    end

    // Hold a finished result until a boundary consumes it; a fresh result overrides a consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_valid  <= 1'b0;
            pending_period <= '0;
            pending_freq   <= '0;
        end else if (div_done) begin
            pending_valid  <= 1'b1;
            pending_period <= {quo[PER_W-2:0], q_bit};
            pending_freq   <= divisor;
        end else if (load_period) begin
            pending_valid  <= 1'b0;
        end
    end

    // The period being driven changes only when the sequencer takes a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cycles <= '0;
            freq_applied  <= '0;
        end else if (load_period) begin
            period_cycles <= pending_period;
            freq_applied  <= pending_freq;
        end
    end

    // Phase lengths; the odd cycle of an odd period goes to the low half.
    always_comb begin
        half   = period_cycles >> 1;
        hi_len = half - DEAD - ONE;
        lo_len = period_cycles - half - DEAD - ONE;
    end

    // Sequencer state and phase down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
        end
    end

    // Next-state logic: each phase counts down to zero, enable low forces IDLE.
    always_comb begin
        state_next  = state;
        phase_next  = phase_cnt;
        load_period = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            phase_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_valid || (period_cycles != '0)) begin
                        state_next  = DT_A;
                        phase_next  = DEAD - ONE;
                        load_period = pending_valid;
                    end
                end
                DT_A: begin
                    if (phase_cnt == '0) begin
                        state_next = HI;
                        phase_next = hi_len;
                    end else begin
                        phase_next = phase_cnt - ONE;
                    end
                end
                HI: begin
                    if (phase_cnt == '0) begin
                        state_next = DT_B;
                        phase_next = DEAD - ONE;
                    end else begin
                        phase_next = phase_cnt - ONE;
                    end
                end
                DT_B: begin
                    if (phase_cnt == '0) begin
                        state_next = LO;
                        phase_next = lo_len;
                    end else begin
                        phase_next = phase_cnt - ONE;
                    end
                end
                LO: begin
                    if (phase_cnt == '0) begin
                        state_next  = DT_A;
                        phase_next  = DEAD - ONE;
                        load_period = pending_valid;
                    end else begin
                        phase_next = phase_cnt - ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    phase_next = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered gates line up with it.
    always_comb begin
        gate_hi_d = (state_next == HI);
        gate_lo_d = (state_next == LO);
        start_d   = (state_next == DT_A) && (state != DT_A);
    end

    // Registered gate drive and period marker; HI and LO are exclusive states.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_hi      <= 1'b0;
            gate_lo      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            gate_hi      <= gate_hi_d;
            gate_lo      <= gate_lo_d;
            period_start <= start_d;
        end
    end

endmodule

// File: tb/tb_swipt_gate_drive.sv
`timescale 1ns/1ps
// tb_swipt_gate_drive
// Directed scenarios plus randomized frequency/enable/reset traffic, checked
// every cycle against a period-position model of the gate driver.
module tb_swipt_gate_drive;

    localparam int CLK_HZ   = 100_000_000;
    localparam int PER_W    = 24;
    localparam int DEADTIME = 50;
    localparam int FMIN     = 30000;
    localparam int FMAX     = 50000;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [19:0]      freq;
    logic             gate_hi;
    logic             gate_lo;
    logic [PER_W-1:0] period_cycles;
    logic [19:0]      freq_applied;
    logic             period_start;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Model state: divider countdown, pending result, position inside the period.
    int m_busy_left = 0;
    int m_last_req  = 0;
    int m_div_f     = 0;
    int m_pv        = 0;
    int m_pend_p    = 0;
    int m_pend_f    = 0;
    int m_run       = 0;
    int m_pos       = 0;
    int m_p         = 0;
    int m_f         = 0;

    logic [47:0] cmp_exp;
    logic [47:0] cmp_act;
    int          cmp_half;

    swipt_gate_drive #(
        .CLK_HZ  (CLK_HZ),
        .PER_W   (PER_W),
        .DEADTIME(DEADTIME),
        .FMIN    (FMIN),
        .FMAX    (FMAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .freq         (freq),
        .gate_hi      (gate_hi),
        .gate_lo      (gate_lo),
        .period_cycles(period_cycles),
        .freq_applied (freq_applied),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic int clampFreq(input int f);
        if (f < FMIN) return FMIN;
        if (f > FMAX) return FMAX;
        return f;
    endfunction

    task automatic finishBench();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
            if (failures >= 200) finishBench();
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [19:0] f);
        rst    = r;
        enable = e;
        freq   = f;
    endtask

    task automatic waitPeriodStart(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < budget);
        checkOutput({name, "_seen"}, 48'(period_start), 48'd1);
    endtask

    // Called on the first cycle of a period; stops on the first cycle of the next one.
    task automatic measurePeriod(output int len, output int hi, output int lo, output int lead);
        int seen;
        len = 0; hi = 0; lo = 0; lead = 0; seen = 0;
        do begin
            if (gate_hi) begin
                hi++;
                seen = 1;
            end
            if (gate_lo) lo++;
            if (seen == 0) lead++;
            len++;
            @(negedge clk);
        end while (!period_start && len < 10000);
    endtask

    // Reference model: advances once per rising edge from the sampled inputs.
    initial begin
        int old_pv;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy_left = 0; m_last_req = 0; m_div_f = 0;
                m_pv = 0; m_pend_p = 0; m_pend_f = 0;
                m_run = 0; m_pos = 0; m_p = 0; m_f = 0;
            end else begin
                old_pv = m_pv;
                if (!enable) begin
                    m_run = 0;
                end else if (m_run == 0) begin
                    if (old_pv != 0 || m_p != 0) begin
                        if (old_pv != 0) begin
                            m_p = m_pend_p; m_f = m_pend_f; m_pv = 0;
                        end
                        m_run = 1;
                        m_pos = 0;
                    end
                end else begin
                    m_pos++;
                    if (m_pos == m_p) begin
                        m_pos = 0;
                        if (old_pv != 0) begin
                            m_p = m_pend_p; m_f = m_pend_f; m_pv = 0;
                        end
                    end
                end
                if (m_busy_left > 0) begin
                    m_busy_left--;
                    if (m_busy_left == 0) begin
                        m_pend_p = (CLK_HZ / m_div_f) & ((1 << PER_W) - 1);
                        m_pend_f = m_div_f;
                        m_pv     = 1;
                    end
                end else if (clampFreq(int'(freq)) != m_last_req) begin
                    m_last_req  = clampFreq(int'(freq));
                    m_div_f     = m_last_req;
                    m_busy_left = 32;
                end
            end
        end
    end

    // Compare process: every cycle, all outputs against the model, plus gate exclusivity.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cmp_half = m_p / 2;
            cmp_exp = {(m_run != 0 && m_pos >= DEADTIME && m_pos < cmp_half),
                       (m_run != 0 && m_pos >= cmp_half + DEADTIME),
                       (m_run != 0 && m_pos == 0),
                       (m_busy_left > 0),
                       24'(m_p), 20'(m_f)};
            cmp_act = {gate_hi, gate_lo, period_start, busy, period_cycles, freq_applied};
            checkOutput("model_outputs", cmp_act, cmp_exp);
            checkOutput("no_overlap", 48'(gate_hi & gate_lo), 48'd0);
        end
    end

    initial begin
        #1_200_000;
        checkOutput("watchdog_expired", 48'd1, 48'd0);
        finishBench();
    end

    initial begin
        int n, cnt, len, hi, lo, lead, w, r, total;

        // Reset, first divide and first period at 35 kHz.
        applyStimulus(1'b1, 1'b1, 20'd35000);
        repeat (3) @(negedge clk);
        checkOutput("reset_state",
                    {gate_hi, gate_lo, period_start, busy, period_cycles, freq_applied}, 48'd0);
        applyStimulus(1'b0, 1'b1, 20'd35000);
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("t1_busy_len", 48'(cnt), 48'd32);
        waitPeriodStart(200, "t1_start");
        checkOutput("t1_period", 48'(period_cycles), 48'd2857);
        checkOutput("t1_freq", 48'(freq_applied), 48'd35000);
        measurePeriod(len, hi, lo, lead);
        checkOutput("t1_len", 48'(len), 48'd2857);
        checkOutput("t1_hi", 48'(hi), 48'd1378);
        checkOutput("t1_lo", 48'(lo), 48'd1379);
        checkOutput("t1_lead", 48'(lead), 48'd50);

        // Clamping below and above the band.
        applyStimulus(1'b0, 1'b1, 20'd20000);
        repeat (40) @(negedge clk);
        waitPeriodStart(4000, "t2a_start");
        checkOutput("t2a_period", 48'(period_cycles), 48'd3333);
        checkOutput("t2a_freq", 48'(freq_applied), 48'd30000);
        applyStimulus(1'b0, 1'b1, 20'd60000);
        repeat (40) @(negedge clk);
        waitPeriodStart(5000, "t2b_start");
        checkOutput("t2b_period", 48'(period_cycles), 48'd2000);
        checkOutput("t2b_freq", 48'(freq_applied), 48'd50000);
        measurePeriod(len, hi, lo, lead);
        checkOutput("t2b_len", 48'(len), 48'd2000);
        checkOutput("t2b_hi", 48'(hi), 48'd950);
        checkOutput("t2b_lo", 48'(lo), 48'd950);

        // Change request in the middle of HI; the running period must complete untouched.
        applyStimulus(1'b0, 1'b1, 20'd35000);
        repeat (40) @(negedge clk);
        waitPeriodStart(4000, "t3_sync");
        checkOutput("t3_period_old", 48'(period_cycles), 48'd2857);
        len = 0;
        do begin
            if (len == 600) applyStimulus(1'b0, 1'b1, 20'd45000);
            len++;
            @(negedge clk);
        end while (!period_start && len < 10000);
        checkOutput("t3_len_old", 48'(len), 48'd2857);
        checkOutput("t3_period_new", 48'(period_cycles), 48'd2222);
        checkOutput("t3_freq_new", 48'(freq_applied), 48'd45000);
        measurePeriod(len, hi, lo, lead);
        checkOutput("t3_len_new", 48'(len), 48'd2222);
        checkOutput("t3_hi_new", 48'(hi), 48'd1061);

        // Two requests while busy: only the latest reaches the gates.
        applyStimulus(1'b0, 1'b1, 20'd35000);
        repeat (40) @(negedge clk);
        waitPeriodStart(4000, "t4_sync");
        checkOutput("t4_period_old", 48'(period_cycles), 48'd2857);
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'd40000);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'd45000);
        waitPeriodStart(4000, "t4_start");
        checkOutput("t4_period", 48'(period_cycles), 48'd2222);
        checkOutput("t4_freq", 48'(freq_applied), 48'd45000);

        // Enable drop during HI, then re-enable after 100 cycles.
        n = 0;
        while (!gate_hi && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_hi_seen", 48'(gate_hi), 48'd1);
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'd45000);
        @(negedge clk);
        checkOutput("t5_gates_off", 48'({gate_hi, gate_lo}), 48'd0);
        repeat (99) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'd45000);
        @(negedge clk);
        checkOutput("t5_restart_pulse", 48'(period_start), 48'd1);
        n = 0;
        while (!gate_hi && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("t5_restart_dead", 48'(n), 48'd50);
        checkOutput("t5_period_kept", 48'(period_cycles), 48'd2222);

        // Reset during LO with an update pending; a fresh divide is needed afterwards.
        waitPeriodStart(3000, "t6_sync");
        applyStimulus(1'b0, 1'b1, 20'd30000);
        n = 0;
        while (!gate_lo && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_lo_seen", 48'(gate_lo), 48'd1);
        applyStimulus(1'b1, 1'b1, 20'd30000);
        @(negedge clk);
        checkOutput("t6_reset_outputs",
                    {gate_hi, gate_lo, period_start, busy, period_cycles, freq_applied}, 48'd0);
        applyStimulus(1'b0, 1'b1, 20'd30000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 200);
        checkOutput("t6_first_start_delay", 48'(n), 48'd34);
        checkOutput("t6_period", 48'(period_cycles), 48'd3333);

        // Randomized traffic, checked cycle by cycle against the model.
        total = 0;
        while (total < 20000) begin
            w = $urandom_range(1, 2500);
            repeat (w) @(negedge clk);
            total += w;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                applyStimulus(1'b0, enable, 20'($urandom_range(15000, 70000)));
            end else if (r < 70) begin
                applyStimulus(1'b0, enable, 20'($urandom_range(0, 1048575)));
            end else if (r < 85) begin
                applyStimulus(1'b0, ~enable, freq);
            end else if (r < 92) begin
                applyStimulus(1'b1, enable, freq);
                repeat ($urandom_range(1, 2)) @(negedge clk);
                applyStimulus(1'b0, enable, freq);
            end else begin
                applyStimulus(1'b0, enable, 20'($urandom_range(29000, 31000)));
            end
        end
        repeat (10) @(negedge clk);
        $display("[TB] random phase covered %0d cycles", total);
        finishBench();
    end

endmodule
